hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/clear strobes and divider sequencing.
// Optional HAZARD_PERF_EN adds stall-cycle and flush performance counters.
module hazard_ctrl #(
    parameter int DIV_CYCLES = 34,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_load,
    input  logic       ex_div_req,
    input  logic       bj_en,
    input  logic       trap_en,
    input  logic       mem_busy,
`ifdef HAZARD_PERF_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes,
`endif
    output logic       if_id_stall,
    output logic       if_id_clear,
    output logic       id_ex_stall,
    output logic       id_ex_clear,
    output logic       ex_mem_stall,
    output logic       div_done
);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    logic div_stall;
    logic load_use;
    logic redirect;
    logic ex_hold;
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    assign redirect = bj_en || trap_en;

    assign div_stall = ((state == RUN) && ex_div_req) || (state == DIV);
    assign ex_hold   = mem_busy || div_stall;

    // Divider sequencer next-state: RUN -> DIV (count down) -> DONE -> RUN
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            RUN: begin
                if (ex_div_req && !trap_en) begin
                    state_n = DIV;
                    cnt_n   = CNT_W'(DIV_CYCLES - 2);
                end
            end
            DIV: begin
                if (trap_en) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else if (cnt == '0) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (!mem_busy) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
    end

    // Sequencer state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Strobes; redirects never flush a held stage, and everything is quiet in reset
    always_comb begin
        ex_mem_stall = !rst && mem_busy;
        id_ex_stall  = !rst && ex_hold;
        if_id_stall  = !rst && (ex_hold || (load_use && !redirect));
        id_ex_clear  = !rst && load_use && !ex_hold && !redirect;
        if_id_clear  = !rst && redirect && !ex_hold;
        div_done     = !rst && (state == DONE);
    end

`ifdef HAZARD_PERF_EN
    // Free-running wrap-around counters of stalled and flushed front-end cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (if_id_stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (if_id_clear) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus queues expected strobes,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_load;
    logic       ex_div_req;
    logic       bj_en;
    logic       trap_en;
    logic       mem_busy;
    logic       if_id_stall;
    logic       if_id_clear;
    logic       id_ex_stall;
    logic       id_ex_clear;
    logic       ex_mem_stall;
    logic       div_done;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushes;
`endif

    int checks = 0;
    int fails  = 0;

    logic [5:0] exp_q[$];
    string      name_q[$];

    // {if_id_stall, if_id_clear, id_ex_stall, id_ex_clear, ex_mem_stall, div_done}
    localparam logic [5:0] IDLE  = 6'b000000;
    localparam logic [5:0] LU    = 6'b100100;
    localparam logic [5:0] RDIR  = 6'b010000;
    localparam logic [5:0] HOLD  = 6'b101000;
    localparam logic [5:0] MHOLD = 6'b101010;
    localparam logic [5:0] DDONE = 6'b000001;
    localparam logic [5:0] DBUSY = 6'b101011;

    hazard_ctrl #(.DIV_CYCLES(34), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_load     (ex_load),
        .ex_div_req  (ex_div_req),
        .bj_en       (bj_en),
        .trap_en     (trap_en),
        .mem_busy    (mem_busy),
`ifdef HAZARD_PERF_EN
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flushes     (perf_flushes),
`endif
        .if_id_stall (if_id_stall),
        .if_id_clear (if_id_clear),
        .id_ex_stall (id_ex_stall),
        .id_ex_clear (id_ex_clear),
        .ex_mem_stall(ex_mem_stall),
        .div_done    (div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the DUT strobes against the queued expectation each cycle
    initial begin
        logic [5:0] got;
        logic [5:0] e;
        string      nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                got = {if_id_stall, if_id_clear, id_ex_stall,
                       id_ex_clear, ex_mem_stall, div_done};
                checks++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL %s: got %b expected %b", nm, got, e);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic [5:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        id_rs1     = 5'd0;
        id_rs2     = 5'd0;
        id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0;
        ex_rd      = 5'd0;
        ex_load    = 1'b0;
        ex_div_req = 1'b0;
        bj_en      = 1'b0;
        trap_en    = 1'b0;
        mem_busy   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clr_in();
        @(posedge clk);
        #1;
        cyc("reset_idle", IDLE);
        mem_busy   = 1'b1;
        ex_div_req = 1'b1;
        cyc("reset_gated", IDLE);
        rst = 1'b0;
        clr_in();
        cyc("idle", IDLE);

        ex_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        cyc("load_use_rs1", LU);
        ex_load = 1'b0;
        cyc("load_use_gone", IDLE);

        clr_in();
        ex_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        cyc("x0_no_hazard", IDLE);
        clr_in();
        ex_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b0;
        cyc("rs2_unused", IDLE);
        id_use_rs2 = 1'b1;
        cyc("load_use_rs2", LU);
        ex_load = 1'b0;
        cyc("non_load", IDLE);

        ex_load = 1'b1; bj_en = 1'b1;
        cyc("redirect_wins", RDIR);
        clr_in();

        bj_en = 1'b1; mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) cyc("mem_hold", MHOLD);
        mem_busy = 1'b0;
        cyc("mem_release_flush", RDIR);
        clr_in();
        cyc("idle2", IDLE);

        ex_div_req = 1'b1;
        for (int i = 0; i < 34; i++) cyc("div_stall", HOLD);
        cyc("div_done", DDONE);
        ex_div_req = 1'b0;
        cyc("div_after", IDLE);

        ex_div_req = 1'b1;
        for (int i = 0; i < 34; i++) cyc("div2_stall", HOLD);
        mem_busy = 1'b1;
        cyc("done_busy", DBUSY);
        cyc("done_busy2", DBUSY);
        mem_busy = 1'b0;
        cyc("done_release", DDONE);
        ex_div_req = 1'b0;
        cyc("div2_after", IDLE);

        ex_div_req = 1'b1; trap_en = 1'b1;
        cyc("div_req_trap_run", HOLD);
        clr_in();
        cyc("no_div_entry", IDLE);

        ex_div_req = 1'b1;
        cyc("abort_run", HOLD);
        for (int i = 0; i < 9; i++) cyc("abort_div", HOLD);
        trap_en = 1'b1;
        cyc("trap_held", HOLD);
        ex_div_req = 1'b0;
        cyc("trap_flush", RDIR);
        trap_en = 1'b0;
        cyc("abort_quiet", IDLE);
        cyc("abort_no_done", IDLE);

        ex_div_req = 1'b1;
        for (int i = 0; i < 5; i++) cyc("pre_rst_div", HOLD);
        rst = 1'b1;
        cyc("rst_mid_div", IDLE);
        rst = 1'b0;
        ex_div_req = 1'b0;
        cyc("rst_release", IDLE);
        cyc("rst_release2", IDLE);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
